debug_unit: RTL
===============

// Module: debug_unit
// PURPOSE
//  Debug controller on the far side of the multicycle CPU's debug read ports (regfile ra2/rd2, data-memory debug port).
//  Gates CPU execution (free run / single instruction step).
//  Walks a debug address with inc/dec buttons and registers the selected CPU status word for the LED/7-seg display.
//  Sits between board switches/buttons and the CPU top; the CPU advances only while run=1.
// PARAMETERS
//  WIDTH      32   data width of all observed words
//  ADDR_W     8    debug address width (regfile uses addr[4:0], memory uses full addr)
//  MEM_LAT    1    memory debug-port read latency in cycles (synchronous read)
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  succ       in   1       switch: 1 = continuous run, 0 = step mode
//  step       in   1       raw button: execute one instruction (step mode only)
//  inc        in   1       raw button: debug address +1
//  dec        in   1       raw button: debug address -1
//  m_rf       in   1       view select: 1 = data memory, 0 = register file
//  sel        in   3       display select (see BEHAVIOUR)
//  instr_done in   1       CPU pulse: last cycle of an instruction (FSM returning to fetch)
//  rf_data    in   WIDTH   regfile debug read data (rd2), combinational from dbg_addr[4:0]
//  mem_data   in   WIDTH   memory debug read data, valid MEM_LAT cycles after dbg_addr changes
//  pc, ir, mdr, a, b, alu_out   in  WIDTH each   CPU datapath registers
//  ctrl       in   16      CPU control word {PCWriteCond,PCSource,PCWrite,ALUOp,IorD,ALUSrcB,ALUSrcA,MemWrite,RegWrite,MemRead,MemtoReg,IRWrite,RegDst}
//  run        out  1       CPU clock enable
//  dbg_addr   out  ADDR_W  debug read address (to ra2 and memory debug port)
//  display    out  WIDTH   registered word for 7-seg
//  led        out  16      {m_rf, succ, run, 5'b0, dbg_addr}
// BEHAVIOUR
//  Reset: run=0, dbg_addr=0, display=0, FSM=IDLE, edge-detect flops=0; all asynchronous.
//  Button inputs pass through 2-flop sync plus rising-edge detect.
//    One clk pulse per press; edge is visible 2 cycles after the input rises.
//  FSM, run is a Moore output:
//    IDLE  (run=0): succ=1 -> FREE. step edge with succ=0 -> STEP.
//    STEP  (run=1): instr_done=1 -> IDLE (run drops next cycle; exactly one instruction retires).
//                   succ going to 1 -> FREE.
//    FREE  (run=1): succ=0 -> DRAIN.
//    DRAIN (run=1): instr_done=1 -> IDLE. CPU never stops mid-instruction.
//    step edges outside IDLE are ignored, not queued.
//  Address: inc edge -> dbg_addr+1, wraps 2^ADDR_W-1 -> 0. dec edge -> dbg_addr-1, wraps 0 -> max.
//    inc and dec in the same cycle -> no change.
//    Address changes are accepted in every FSM state.
//  display, registered every cycle:
//    sel=0: m_rf ? mem_data : rf_data. Memory view waits for mem_data validity:
//      after a dbg_addr change or a m_rf 0->1, display holds its previous value for MEM_LAT cycles.
//    sel=1: pc     sel=2: ir     sel=3: mdr     sel=4: a     sel=5: b     sel=6: alu_out
//    sel=7: {16'b0, ctrl}
//  Regfile view: rf_data reflects reg dbg_addr[4:0]. Address bits [7:5] are ignored for the regfile.
//  Reset mid-STEP/FREE: run drops immediately (async). CPU resets on the same rst.
// STRUCTURE
//  Shared package/header: FSM state encodings (IDLE/STEP/FREE/DRAIN), sel codes, ctrl bit positions.
//  Sub-module: btn_edge (2-flop sync + rising-edge pulse, async rst), instantiated 3x (step, inc, dec).
//  FSM, address counter, display mux/register and memory-latency counter stay in debug_unit.
// TESTING
//  1. Reset, succ=0, press step, CPU model pulses instr_done after 4 run cycles:
//     run high exactly 4 cycles, then 0; pc advanced by 4.
//  2. succ=1 for 20 cycles, then 0 in the 2nd cycle of a 5-cycle instr:
//     run stays 1 until instr_done, then 0; no partial instruction.
//  3. dbg_addr=0, dec press -> 0xFF.
//     inc press -> 0x00.
//     inc and dec in the same cycle -> unchanged.
//  4. m_rf=0, sel=0, addr=5, reg5=0x1234 -> display=0x1234 one cycle later.
//     m_rf=1, mem[5]=0xBEEF -> display holds old value MEM_LAT cycles, then 0xBEEF.
//  5. sel sweep 1..7 with distinct input patterns -> display matches each source.
//     sel=7 shows the upper half zero.
//  6. Assert rst during STEP -> run=0, dbg_addr=0, display=0 same cycle.
//     Step press while in FREE is ignored.

Source files
------------

// File: rtl/debug_unit_pkg.sv
// Shared definitions for the debug controller: FSM states, display select codes
// and the layout of the CPU control word shown on the display.
package debug_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP  = 2'd1,
    ST_FREE  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    SEL_RF_MEM  = 3'd0,
    SEL_PC      = 3'd1,
    SEL_IR      = 3'd2,
    SEL_MDR     = 3'd3,
    SEL_A       = 3'd4,
    SEL_B       = 3'd5,
    SEL_ALU_OUT = 3'd6,
    SEL_CTRL    = 3'd7
  } sel_e;

  // MSB first, matching the order the CPU packs its control word
  typedef struct packed {
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       pc_write;
    logic [1:0] alu_op;
    logic       i_or_d;
    logic [1:0] alu_src_b;
    logic       alu_src_a;
    logic       mem_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_dst;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/debug_unit_btn_edge.sv
// Button conditioner: two-flop synchronizer followed by a rising-edge detector,
// giving one clock pulse per press, visible two cycles after the button rises.
module debug_unit_btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse = sync2 & ~prev;

endmodule

// File: rtl/debug_unit.sv
// Debug controller for the multicycle CPU: gates execution (free run / single step),
// walks a debug address and registers the selected status word for the display.
module debug_unit
  import debug_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              succ,
  input  logic              step,
  input  logic              inc,
  input  logic              dec,
  input  logic              m_rf,
  input  logic [2:0]        sel,
  input  logic              instr_done,
  input  logic [WIDTH-1:0]  rf_data,
  input  logic [WIDTH-1:0]  mem_data,
  input  logic [WIDTH-1:0]  pc,
  input  logic [WIDTH-1:0]  ir,
  input  logic [WIDTH-1:0]  mdr,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic [15:0]       ctrl,
  output logic              run,
  output logic [ADDR_W-1:0] dbg_addr,
  output logic [WIDTH-1:0]  display,
  output logic [15:0]       led
);

  localparam int LAT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

  logic step_e;
  logic inc_e;
  logic dec_e;

  debug_unit_btn_edge u_step_edge (.clk(clk), .rst(rst), .btn(step), .pulse(step_e));
  debug_unit_btn_edge u_inc_edge  (.clk(clk), .rst(rst), .btn(inc),  .pulse(inc_e));
  debug_unit_btn_edge u_dec_edge  (.clk(clk), .rst(rst), .btn(dec),  .pulse(dec_e));

  state_e state;
  state_e state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Leaving run mode always waits for instr_done so the CPU never stops mid-instruction
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (succ)        state_next = ST_FREE;
        else if (step_e) state_next = ST_STEP;
      end
      ST_STEP: begin
        if (instr_done) state_next = ST_IDLE;
        else if (succ)  state_next = ST_FREE;
      end
      ST_FREE: begin
        if (!succ) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (instr_done) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign run = (state != ST_IDLE);

  logic addr_move;
  assign addr_move = inc_e ^ dec_e;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 dbg_addr <= '0;
    else if (inc_e & ~dec_e) dbg_addr <= dbg_addr + ADDR_W'(1);
    else if (dec_e & ~inc_e) dbg_addr <= dbg_addr - ADDR_W'(1);
  end

  // mem_data lags dbg_addr, so the memory view freezes until the new word arrives
  logic             m_rf_q;
  logic             mem_rise;
  logic             mem_hold;
  logic [LAT_W-1:0] mem_wait;

  assign mem_rise = m_rf & ~m_rf_q;
  assign mem_hold = (mem_wait != '0) | ((MEM_LAT > 0) & mem_rise);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rf_q   <= 1'b0;
      mem_wait <= '0;
    end else begin
      m_rf_q <= m_rf;
      if (addr_move && (MEM_LAT > 0))     mem_wait <= LAT_W'(MEM_LAT);
      else if (mem_rise && (MEM_LAT > 1)) mem_wait <= LAT_W'(MEM_LAT - 1);
      else if (mem_wait != '0)            mem_wait <= mem_wait - LAT_W'(1);
    end
  end

  ctrl_t            ctrl_word;
  logic [WIDTH-1:0] display_next;

  assign ctrl_word = ctrl;

  always_comb begin
    display_next = display;
    case (sel_e'(sel))
      SEL_RF_MEM: begin
        if (!m_rf)          display_next = rf_data;
        else if (!mem_hold) display_next = mem_data;
      end
      SEL_PC:      display_next = pc;
      SEL_IR:      display_next = ir;
      SEL_MDR:     display_next = mdr;
      SEL_A:       display_next = a;
      SEL_B:       display_next = b;
      SEL_ALU_OUT: display_next = alu_out;
      SEL_CTRL:    display_next = WIDTH'(ctrl_word);
      default:     display_next = display;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) display <= '0;
    else     display <= display_next;
  end

  assign led = {m_rf, succ, run, 5'b0, 8'(dbg_addr)};

endmodule
